// File: rtl/mem_responder.sv
// Fixed-latency word-array responder with byte/halfword/word lanes and rotated unaligned word reads.
// Optional MEM_ALIGN_FAULT_EN flags misaligned halfword/word accesses and suppresses their effects.
module mem_responder #(
    parameter int LATENCY    = 3,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CS,
    input  logic        R_W,
    input  logic [1:0]  SIZE,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        MEM_R,
    output logic [31:0] RDATA,
    output logic        MEM_ERR
);
    // state | meaning
    // IDLE  | waiting for CS, request fields latched on accept
    // WAIT  | counting down latency, CS low aborts
    // DONE  | one-cycle MEM_R pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int         AW     = DEPTH_LOG2 + 2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            rw_q;
    logic [1:0]      size_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            accept, commit, we, fault;

    logic            req_rw;
    logic [1:0]      req_size;
    logic [AW-1:0]   req_addr;
    logic [31:0]     req_wdata;
    logic [DEPTH_LOG2-1:0] idx;
    logic [3:0]      be;
    logic [31:0]     wlane, word, rword, shifted;
    logic [63:0]     rot;
    logic            unused_addr;

    logic [31:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (accept) begin
                rw_q    <= R_W;
                size_q  <= SIZE;
                addr_q  <= ADDR[AW-1:0];
                wdata_q <= WDATA;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (CS) begin
                    accept = 1'b1;
                    cnt_d  = LAT_M1;
                    if (LATENCY == 1) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!CS) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = DONE;
                        commit  = 1'b1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        MEM_R   = (state_q == DONE);
        MEM_ERR = err_q;
        RDATA   = rdata_q;
    end

    // With LATENCY=1 the commit happens on the accepting edge, so use the live inputs then.
    always_comb begin
        if (state_q == IDLE) begin
            req_rw    = R_W;
            req_size  = SIZE;
            req_addr  = ADDR[AW-1:0];
            req_wdata = WDATA;
        end else begin
            req_rw    = rw_q;
            req_size  = size_q;
            req_addr  = addr_q;
            req_wdata = wdata_q;
        end
    end

`ifdef MEM_ALIGN_FAULT_EN
    assign fault = ((req_size == 2'b01) && req_addr[0]) ||
                   (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign fault = 1'b0;
`endif

    assign unused_addr = ^ADDR[31:AW];
    assign idx         = req_addr[AW-1:2];
    assign word        = mem[idx];
    assign shifted     = word >> {req_addr[1:0], 3'b000};
    assign rot         = {word, word} >> {req_addr[1:0], 3'b000};
    assign we          = commit && req_rw && !fault;

    always_comb begin
        case (req_size)
            2'b00: begin
                be    = 4'b0001 << req_addr[1:0];
                wlane = {4{req_wdata[7:0]}};
                rword = {24'b0, shifted[7:0]};
            end
            2'b01: begin
                be    = req_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{req_wdata[15:0]}};
                rword = {16'b0, (req_addr[1] ? word[31:16] : word[15:0])};
            end
            default: begin
                be    = 4'b1111;
                wlane = req_wdata;
                rword = rot[31:0];
            end
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (commit && !req_rw && !fault) rdata_d = rword;
        err_d = commit && fault;
    end

    // Array has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed cases plus randomized traffic against a word-array model.
module tb_mem_responder;
    localparam int LAT = 3;
    localparam int DL  = 10;
    localparam int NW  = 1 << DL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        CS = 1'b0, R_W = 1'b0;
    logic [1:0]  SIZE = 2'b00;
    logic [31:0] ADDR = '0, WDATA = '0;
    logic        MEM_R, MEM_ERR;
    logic [31:0] RDATA;

    mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL)) dut (
        .clk(clk), .rst(rst), .CS(CS), .R_W(R_W), .SIZE(SIZE), .ADDR(ADDR),
        .WDATA(WDATA), .MEM_R(MEM_R), .RDATA(RDATA), .MEM_ERR(MEM_ERR)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    bit [31:0]   mem_m [NW];
    logic [31:0] rdata_m = '0;
    bit          in_done = 1'b0;
    int          passed = 0, total = 0, pulses = 0, pulse_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[31:2]) % NW;
    endfunction

    function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
`ifdef MEM_ALIGN_FAULT_EN
        return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] mread(input logic [1:0] sz, input logic [31:0] a);
        bit [31:0] w;
        int        sh;
        w  = mem_m[widx(a)];
        sh = 8 * int'(a[1:0]);
        case (sz)
            2'd0:    return (w >> sh) & 32'hFF;
            2'd1:    return a[1] ? (w >> 16) : (w & 32'hFFFF);
            default: return (sh == 0) ? w : ((w >> sh) | (w << (32 - sh)));
        endcase
    endfunction

    task automatic mwrite(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int i, sh;
        i  = widx(a);
        sh = 8 * int'(a[1:0]);
        case (sz)
            2'd0:    mem_m[i][sh +: 8] = d[7:0];
            2'd1:    if (a[1]) mem_m[i][31:16] = d[15:0]; else mem_m[i][15:0] = d[15:0];
            default: mem_m[i] = d;
        endcase
    endtask

    // MEM_R seen at the negedge after the edge entering DONE, i.e. LATENCY-1 edges after accept.
    always @(negedge clk) begin
        if (rst && MEM_R) begin
            exp_t e;
            pulses++;
            chk("mem_r_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("mem_r_time", cyc, e.due);
                chk("rdata", RDATA, e.rdata);
                chk("mem_err", {31'b0, MEM_ERR}, {31'b0, e.err});
            end
        end
    end

    // Called at a negedge; returns at the negedge where MEM_R is high.
    task automatic issue(input bit rw, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   acc, n;
        R_W = rw; SIZE = sz; ADDR = a; WDATA = d; CS = 1'b1;
        acc   = cyc + (in_done ? 2 : 1);
        e.err = misal(sz, a);
        if (!e.err) begin
            if (rw) mwrite(sz, a, d);
            else    rdata_m = mread(sz, a);
        end
        e.rdata = rdata_m;
        e.due   = acc + LAT - 1;
        sb.push_back(e);
        if (in_done) @(posedge clk);
        @(posedge clk);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (MEM_R) break;
            if (n >= 40) begin
                chk("mem_r_timeout", {31'b0, MEM_R}, 32'd1);
                sb.delete();
                break;
            end
        end
        pulse_cyc = cyc;
        in_done   = 1'b1;
    endtask

    task automatic idle(input int n);
        CS = 1'b0;
        in_done = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0, p1, c1;
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int p0, c1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_mem_r", {31'b0, MEM_R}, 32'd0);
        chk("reset_mem_err", {31'b0, MEM_ERR}, 32'd0);
        chk("reset_rdata", RDATA, 32'd0);
        rst = 1'b1;
        idle(1);

        issue(1, 2'd2, 32'h100, 32'hDEADBEEF); idle(1);
        issue(0, 2'd2, 32'h100, 32'h0);
        chk("word_rw", RDATA, 32'hDEADBEEF);
        idle(2);

        issue(1, 2'd2, 32'h100, 32'h11223344);
        issue(1, 2'd0, 32'h101, 32'h0000005A);
        issue(0, 2'd2, 32'h100, 32'h0);
        chk("byte_merge", RDATA, 32'h11225A44);
        idle(1);
        issue(0, 2'd0, 32'h101, 32'h0);
        chk("byte_read", RDATA, 32'h0000005A);
        idle(1);

        issue(0, 2'd2, 32'h102, 32'h0);
`ifdef MEM_ALIGN_FAULT_EN
        chk("unaligned_err", {31'b0, MEM_ERR}, 32'd1);
        chk("unaligned_rdata", RDATA, 32'h0000005A);
`else
        chk("unaligned_err", {31'b0, MEM_ERR}, 32'd0);
        chk("unaligned_rot", RDATA, 32'h5A441122);
`endif
        idle(1);
        issue(1, 2'd2, 32'h102, 32'hFFFFFFFF); idle(1);
        issue(0, 2'd2, 32'h100, 32'h0);
`ifdef MEM_ALIGN_FAULT_EN
        chk("unaligned_wr_suppressed", RDATA, 32'h11225A44);
`else
        chk("unaligned_wr_all_lanes", RDATA, 32'hFFFFFFFF);
`endif
        idle(1);
        issue(1, 2'd2, 32'h100, 32'h11225A44); idle(1);

        issue(0, 2'd2, 32'h100, 32'h0);
        c1 = pulse_cyc;
        issue(0, 2'd1, 32'h102, 32'h0);
        chk("b2b_spacing", pulse_cyc - c1, LAT + 1);
        chk("b2b_half", RDATA, 32'h00001122);
        idle(1);

        issue(1, 2'd2, 32'h200, 32'h12345678); idle(1);
        p0 = pulses;
        R_W = 1'b1; SIZE = 2'd2; ADDR = 32'h200; WDATA = 32'hCAFEF00D; CS = 1'b1;
        @(posedge clk);
        @(negedge clk);
        CS = 1'b0;
        idle(6);
        chk("abort_no_mem_r", pulses, p0);
        chk("abort_rdata_hold", RDATA, rdata_m);
        issue(0, 2'd2, 32'h200, 32'h0);
        chk("abort_no_write", RDATA, 32'h12345678);
        idle(1);

        p0 = pulses;
        R_W = 1'b1; SIZE = 2'd2; ADDR = 32'h200; WDATA = 32'hCAFEF00D; CS = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_rdata", RDATA, 32'd0);
        chk("midreset_mem_r", {31'b0, MEM_R}, 32'd0);
        CS = 1'b0;
        rdata_m = '0;
        @(negedge clk);
        rst = 1'b1;
        idle(5);
        chk("midreset_no_mem_r", pulses, p0);
        issue(0, 2'd2, 32'h200, 32'h0);
        chk("midreset_no_write", RDATA, 32'h12345678);
        idle(1);

        issue(1, 2'd2, 32'h100 + 4 * NW, 32'hA5A50F0F); idle(1);
        issue(0, 2'd2, 32'h100, 32'h0);
        chk("wrap", RDATA, 32'hA5A50F0F);
        idle(1);

        for (int i = 0; i < 16; i++) issue(1, 2'd2, 32'h100 + 4 * i, $urandom);
        idle(1);
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = 32'h100 + $urandom_range(0, 63) + ($urandom_range(0, 15) << 12);
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(3);
        chk("scoreboard_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
